// File: rtl/mem_port_master.sv
// Initiator side of the data-memory port: CPU load/store -> Mem strobes, with RMW for sub-word stores.
// Optional MEM_PORT_PERF_CNT_EN adds saturating load/store completion counters.
module mem_port_master #(
    parameter int AW = 12,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_signed,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    output logic          resp_err,
    output logic [DW-1:0] resp_rdata,
    output logic [AW-3:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_sel,
    output logic          mem_ld,
    output logic          mem_str,
    input  logic [DW-1:0] mem_dout
`ifdef MEM_PORT_PERF_CNT_EN
    ,
    output logic [15:0]   perf_loads,
    output logic [15:0]   perf_stores
`endif
);

    typedef enum logic [2:0] {IDLE, RD, RDW, WR, RESP, ERR} state_e;

    state_e        state_q;
    logic          ready_q, sel_q, ld_q, str_q, resp_valid_q, resp_err_q;
    logic [DW-1:0] din_q, rdata_q;
    logic          we_q, signed_q;
    logic [1:0]    size_q;
    logic [AW-1:0] addr_q;
    logic [15:0]   wdata_q;
    logic          req_bad;

    // Big-endian lanes: byte offset 0 is bits 31:24, half offset 0 is bits 31:16.
    function automatic logic [4:0] byte_shift(input logic [1:0] off);
        return {3'(2'd3 - off), 3'b000};
    endfunction

    function automatic logic [4:0] half_shift(input logic [1:0] off);
        return {~off[1], 4'b0000};
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] size,
                                                input logic [1:0] off, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> byte_shift(off));
        h = 16'(w >> half_shift(off));
        case (size)
            2'b00:   return {{24{sgn & b[7]}}, b};
            2'b01:   return {{16{sgn & h[15]}}, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [1:0] size,
                                                input logic [1:0] off, input logic [15:0] wd);
        logic [31:0] mask;
        case (size)
            2'b00: begin
                mask = 32'h0000_00FF << byte_shift(off);
                return (w & ~mask) | ({24'b0, wd[7:0]} << byte_shift(off));
            end
            default: begin
                mask = 32'h0000_FFFF << half_shift(off);
                return (w & ~mask) | ({16'b0, wd} << half_shift(off));
            end
        endcase
    endfunction

    assign req_bad = (req_size == 2'b11)
                  || (req_size == 2'b01 && req_addr[0])
                  || (req_size == 2'b10 && req_addr[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            sel_q        <= 1'b0;
            ld_q         <= 1'b0;
            str_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            din_q        <= '0;
            rdata_q      <= '0;
            we_q         <= 1'b0;
            signed_q     <= 1'b0;
            size_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            sel_q        <= 1'b0;
            ld_q         <= 1'b0;
            str_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            din_q        <= '0;
            case (state_q)
                IDLE: if (req_valid) begin
                    ready_q  <= 1'b0;
                    we_q     <= req_we;
                    signed_q <= req_signed;
                    size_q   <= req_size;
                    addr_q   <= req_addr;
                    wdata_q  <= req_wdata[15:0];
                    if (req_bad) begin
                        state_q      <= ERR;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        rdata_q      <= '0;
                    end else if (req_we && req_size == 2'b10) begin
                        state_q <= WR;
                        sel_q   <= 1'b1;
                        str_q   <= 1'b1;
                        din_q   <= req_wdata;
                    end else begin
                        state_q <= RD;
                        sel_q   <= 1'b1;
                        ld_q    <= 1'b1;
                    end
                end
                RD: state_q <= RDW;
                RDW: begin
                    // Mem read data is captured here straight into its consumer register.
                    if (we_q) begin
                        state_q <= WR;
                        sel_q   <= 1'b1;
                        str_q   <= 1'b1;
                        din_q   <= store_merge(mem_dout, size_q, addr_q[1:0], wdata_q);
                    end else begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        rdata_q      <= load_extend(mem_dout, size_q, addr_q[1:0], signed_q);
                    end
                end
                WR: begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    rdata_q      <= '0;
                end
                RESP, ERR: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // NOTE: clr gates the strobes combinationally so a write in flight never reaches Mem.
    assign mem_sel    = sel_q & ~clr;
    assign mem_ld     = ld_q & ~clr;
    assign mem_str    = str_q & ~clr;
    assign mem_addr   = mem_sel ? addr_q[AW-1:2] : '0;
    assign mem_din    = mem_sel ? din_q : '0;
    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = rdata_q;

`ifdef MEM_PORT_PERF_CNT_EN
    logic [15:0] perf_loads_q, perf_stores_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            perf_loads_q  <= '0;
            perf_stores_q <= '0;
        end else if (state_q == RESP) begin
            if (we_q && perf_stores_q != 16'hFFFF) perf_stores_q <= perf_stores_q + 16'd1;
            if (!we_q && perf_loads_q != 16'hFFFF) perf_loads_q <= perf_loads_q + 16'd1;
        end
    end

    assign perf_loads  = perf_loads_q;
    assign perf_stores = perf_stores_q;
`endif

endmodule

// File: tb/tb_mem_port_master.sv
// Directed self-checking bench for mem_port_master with a behavioural word-addressed Mem model.
module tb_mem_port_master;

    logic        clk = 1'b0;
    logic        clr;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [9:0]  mem_addr;
    logic [31:0] mem_din;
    logic        mem_sel, mem_ld, mem_str;
    logic [31:0] mem_dout = '0;
`ifdef MEM_PORT_PERF_CNT_EN
    logic [15:0] perf_loads, perf_stores;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int sel_count   = 0;

    logic [31:0] mem_model [0:1023];

    mem_port_master dut (
        .clk        (clk),
        .clr        (clr),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_sel    (mem_sel),
        .mem_ld     (mem_ld),
        .mem_str    (mem_str),
        .mem_dout   (mem_dout)
`ifdef MEM_PORT_PERF_CNT_EN
        ,
        .perf_loads  (perf_loads),
        .perf_stores (perf_stores)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_sel && mem_str) mem_model[mem_addr] <= mem_din;
        if (mem_sel && mem_ld) mem_dout <= mem_model[mem_addr];
        if (mem_sel) sel_count <= sel_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [11:0] addr, input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
    endtask

    task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                           input logic sgn, input logic [11:0] addr, input logic [31:0] wdata,
                           input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata);
        int lat;
        drive(we, size, sgn, addr, wdata);
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_err"}, {31'b0, resp_err}, {31'b0, exp_err});
        check({tag, "_rdata"}, resp_rdata, exp_rdata);
        tick();
        check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        int s0;
        clr = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;
        tick();
        tick();
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_mem_sel", {31'b0, mem_sel}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_mem_addr", {22'b0, mem_addr}, 32'd0);
        clr = 1'b0;
        tick();

        // Word store 0x010 <- DEADBEEF, cycle by cycle
        drive(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF);
        tick();
        req_valid = 1'b0;
        check("ws_c1_str", {31'b0, mem_str}, 32'd1);
        check("ws_c1_ld", {31'b0, mem_ld}, 32'd0);
        check("ws_c1_addr", {22'b0, mem_addr}, 32'd4);
        check("ws_c1_din", mem_din, 32'hDEADBEEF);
        check("ws_c1_ready", {31'b0, req_ready}, 32'd0);
        check("ws_c1_resp", {31'b0, resp_valid}, 32'd0);
        tick();
        check("ws_c2_resp", {31'b0, resp_valid}, 32'd1);
        check("ws_c2_err", {31'b0, resp_err}, 32'd0);
        check("ws_c2_rdata", resp_rdata, 32'd0);
        check("ws_c2_sel", {31'b0, mem_sel}, 32'd0);
        check("ws_c2_addr", {22'b0, mem_addr}, 32'd0);
        tick();
        check("ws_c3_resp", {31'b0, resp_valid}, 32'd0);
        check("ws_mem4", mem_model[4], 32'hDEADBEEF);

        // Word load 0x010, cycle by cycle
        drive(1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
        tick();
        req_valid = 1'b0;
        check("lw_c1_ld", {31'b0, mem_ld}, 32'd1);
        check("lw_c1_str", {31'b0, mem_str}, 32'd0);
        check("lw_c1_addr", {22'b0, mem_addr}, 32'd4);
        check("lw_c1_din", mem_din, 32'd0);
        tick();
        check("lw_c2_sel", {31'b0, mem_sel}, 32'd0);
        check("lw_c2_resp", {31'b0, resp_valid}, 32'd0);
        tick();
        check("lw_c3_resp", {31'b0, resp_valid}, 32'd1);
        check("lw_c3_rdata", resp_rdata, 32'hDEADBEEF);
        tick();
        check("lw_c4_resp", {31'b0, resp_valid}, 32'd0);
        check("lw_c4_hold", resp_rdata, 32'hDEADBEEF);
        check("lw_c4_ready", {31'b0, req_ready}, 32'd1);

        // Byte store RMW at 0x012 onto 11223344
        run_req("pre1", 1'b1, 2'b10, 1'b0, 12'h010, 32'h11223344, 2, 1'b0, 32'h0);
        drive(1'b1, 2'b00, 1'b0, 12'h012, 32'h000000AB);
        tick();
        req_valid = 1'b0;
        check("sb_c1_ld", {31'b0, mem_ld}, 32'd1);
        tick();
        check("sb_c2_sel", {31'b0, mem_sel}, 32'd0);
        tick();
        check("sb_c3_str", {31'b0, mem_str}, 32'd1);
        check("sb_c3_din", mem_din, 32'h1122AB44);
        check("sb_c3_resp", {31'b0, resp_valid}, 32'd0);
        tick();
        check("sb_c4_resp", {31'b0, resp_valid}, 32'd1);
        tick();
        check("sb_mem4", mem_model[4], 32'h1122AB44);

        // Load extension on 80FF7F01
        run_req("pre2", 1'b1, 2'b10, 1'b0, 12'h010, 32'h80FF7F01, 2, 1'b0, 32'h0);
        run_req("lbs0", 1'b0, 2'b00, 1'b1, 12'h010, 32'h0, 3, 1'b0, 32'hFFFFFF80);
        run_req("lbu1", 1'b0, 2'b00, 1'b0, 12'h011, 32'h0, 3, 1'b0, 32'h000000FF);
        run_req("lhs2", 1'b0, 2'b01, 1'b1, 12'h012, 32'h0, 3, 1'b0, 32'h00007F01);
        run_req("lhs0", 1'b0, 2'b01, 1'b1, 12'h010, 32'h0, 3, 1'b0, 32'hFFFF80FF);
        run_req("lbu3", 1'b0, 2'b00, 1'b0, 12'h013, 32'h0, 3, 1'b0, 32'h00000001);
        run_req("sh0", 1'b1, 2'b01, 1'b0, 12'h010, 32'h1234BEEF, 4, 1'b0, 32'h0);
        check("sh0_mem4", mem_model[4], 32'hBEEF7F01);
        run_req("lhu0", 1'b0, 2'b01, 1'b0, 12'h010, 32'h0, 3, 1'b0, 32'h0000BEEF);

        // Misaligned and illegal-size requests
        s0 = sel_count;
        run_req("e_lw13", 1'b0, 2'b10, 1'b0, 12'h013, 32'h0, 1, 1'b1, 32'h0);
        run_req("e_sh11", 1'b1, 2'b01, 1'b0, 12'h011, 32'h5555AAAA, 1, 1'b1, 32'h0);
        run_req("e_sz11", 1'b1, 2'b11, 1'b0, 12'h010, 32'h5555AAAA, 1, 1'b1, 32'h0);
        check("e_no_sel", 32'(sel_count - s0), 32'd0);
        check("e_mem4", mem_model[4], 32'hBEEF7F01);

        // req_valid held through a load while inputs change to a word store
        drive(1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
        tick();
        drive(1'b1, 2'b10, 1'b0, 12'h020, 32'hCAFEF00D);
        check("bz_c1_ld", {31'b0, mem_ld}, 32'd1);
        check("bz_c1_addr", {22'b0, mem_addr}, 32'd4);
        tick();
        check("bz_c2_ready", {31'b0, req_ready}, 32'd0);
        tick();
        check("bz_c3_resp", {31'b0, resp_valid}, 32'd1);
        check("bz_c3_rdata", resp_rdata, 32'hBEEF7F01);
        check("bz_c3_ready", {31'b0, req_ready}, 32'd0);
        tick();
        check("bz_c4_ready", {31'b0, req_ready}, 32'd1);
        check("bz_c4_sel", {31'b0, mem_sel}, 32'd0);
        tick();
        req_valid = 1'b0;
        check("bz_c5_str", {31'b0, mem_str}, 32'd1);
        check("bz_c5_addr", {22'b0, mem_addr}, 32'd8);
        check("bz_c5_din", mem_din, 32'hCAFEF00D);
        tick();
        check("bz_c6_resp", {31'b0, resp_valid}, 32'd1);
        tick();
        check("bz_mem8", mem_model[8], 32'hCAFEF00D);

        // clr during WR of a word store
        drive(1'b1, 2'b10, 1'b0, 12'h010, 32'h12345678);
        tick();
        req_valid = 1'b0;
        check("cl_pre_str", {31'b0, mem_str}, 32'd1);
        clr = 1'b1;
        #1;
        check("cl_str", {31'b0, mem_str}, 32'd0);
        check("cl_sel", {31'b0, mem_sel}, 32'd0);
        check("cl_din", mem_din, 32'd0);
        tick();
        clr = 1'b0;
        check("cl_ready", {31'b0, req_ready}, 32'd1);
        check("cl_resp", {31'b0, resp_valid}, 32'd0);
        tick();
        check("cl_resp2", {31'b0, resp_valid}, 32'd0);
        check("cl_mem4", mem_model[4], 32'hBEEF7F01);

`ifdef MEM_PORT_PERF_CNT_EN
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("pc_rst_loads", {16'b0, perf_loads}, 32'd0);
        run_req("pc_l1", 1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 3, 1'b0, 32'hBEEF7F01);
        run_req("pc_l2", 1'b0, 2'b00, 1'b0, 12'h010, 32'h0, 3, 1'b0, 32'h000000BE);
        run_req("pc_s1", 1'b1, 2'b10, 1'b0, 12'h024, 32'h01020304, 2, 1'b0, 32'h0);
        run_req("pc_e1", 1'b0, 2'b10, 1'b0, 12'h012, 32'h0, 1, 1'b1, 32'h0);
        run_req("pc_s2", 1'b1, 2'b00, 1'b0, 12'h027, 32'h000000FF, 4, 1'b0, 32'h0);
        run_req("pc_l3", 1'b0, 2'b10, 1'b0, 12'h024, 32'h0, 3, 1'b0, 32'h010203FF);
        check("pc_loads", {16'b0, perf_loads}, 32'd3);
        check("pc_stores", {16'b0, perf_stores}, 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
